// File: rtl/ecc_apb_sequencer.sv
// APB master for the ECC_ENC_DEC register bank: one host request becomes four
// register writes, a bounded wait for operation_done, and one response.
module ecc_apb_sequencer #(
  parameter int unsigned                AMBA_ADDR_WIDTH = 20,
  parameter int unsigned                AMBA_WORD       = 32,
  parameter int unsigned                DATA_WIDTH      = 32,
  parameter logic [AMBA_ADDR_WIDTH-1:0] REG_BASE        = '0,
  parameter int unsigned                TIMEOUT_CYCLES  = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [1:0]                 req_op,
  input  logic [AMBA_WORD-1:0]       req_data,
  input  logic [1:0]                 req_width,
  input  logic [AMBA_WORD-1:0]       req_noise,
  output logic [AMBA_ADDR_WIDTH-1:0] PADDR,
  output logic [AMBA_WORD-1:0]       PWDATA,
  output logic                       PSEL,
  output logic                       PENABLE,
  output logic                       PWRITE,
  input  logic                       operation_done,
  input  logic [DATA_WIDTH-1:0]      data_out,
  input  logic [1:0]                 num_of_errors,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [DATA_WIDTH-1:0]      rsp_data,
  output logic [1:0]                 rsp_num_err,
  output logic [1:0]                 rsp_status
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [1:0] ST_OK        = 2'b00;
  localparam logic [1:0] ST_TIMEOUT   = 2'b01;
  localparam logic [1:0] ST_BAD_WIDTH = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_ACCESS,
    S_WAIT_DONE,
    S_RESP
  } state_t;

  state_t               state, state_nxt;
  logic [1:0]           idx, idx_nxt, idx_inc;
  logic [CNT_W-1:0]     cnt, cnt_nxt;
  logic [1:0]           op_q, width_q;
  logic [AMBA_WORD-1:0] noise_q;
  logic                 accept;

  logic                       req_ready_nxt;
  logic                       psel_nxt, penable_nxt, pwrite_nxt;
  logic [AMBA_ADDR_WIDTH-1:0] paddr_nxt;
  logic [AMBA_WORD-1:0]       pwdata_nxt;
  logic                       rsp_valid_nxt;
  logic [DATA_WIDTH-1:0]      rsp_data_nxt;
  logic [1:0]                 rsp_num_err_nxt;
  logic [1:0]                 rsp_status_nxt;

  // Write index 0..3 maps to DATA_IN, CODEWORD_WIDTH, NOISE, CTRL (offsets 1,2,3,0 words)
  function automatic logic [AMBA_ADDR_WIDTH-1:0] reg_addr(input logic [1:0] i);
    logic [1:0] slot;
    slot = i + 2'd1;
    return REG_BASE + AMBA_ADDR_WIDTH'({slot, 2'b00});
  endfunction

  assign accept = (state == S_IDLE) && req_valid && req_ready;

  always_comb begin
    state_nxt       = state;
    idx_nxt         = idx;
    cnt_nxt         = cnt;
    idx_inc         = idx + 2'd1;
    req_ready_nxt   = req_ready;
    psel_nxt        = 1'b0;
    penable_nxt     = 1'b0;
    pwrite_nxt      = 1'b0;
    paddr_nxt       = PADDR;
    pwdata_nxt      = PWDATA;
    rsp_valid_nxt   = rsp_valid;
    rsp_data_nxt    = rsp_data;
    rsp_num_err_nxt = rsp_num_err;
    rsp_status_nxt  = rsp_status;

    case (state)
      S_IDLE: begin
        if (accept) begin
          req_ready_nxt = 1'b0;
          if (req_width == 2'd3) begin
            state_nxt       = S_RESP;
            rsp_valid_nxt   = 1'b1;
            rsp_data_nxt    = '0;
            rsp_num_err_nxt = '0;
            rsp_status_nxt  = ST_BAD_WIDTH;
          end else begin
            state_nxt  = S_SETUP;
            idx_nxt    = 2'd0;
            psel_nxt   = 1'b1;
            pwrite_nxt = 1'b1;
            paddr_nxt  = reg_addr(2'd0);
            pwdata_nxt = req_data;
          end
        end
      end

      S_SETUP: begin
        state_nxt   = S_ACCESS;
        psel_nxt    = 1'b1;
        penable_nxt = 1'b1;
        pwrite_nxt  = 1'b1;
      end

      S_ACCESS: begin
        if (idx == 2'd3) begin
          state_nxt = S_WAIT_DONE;
          cnt_nxt   = '0;
        end else begin
          state_nxt  = S_SETUP;
          idx_nxt    = idx_inc;
          psel_nxt   = 1'b1;
          pwrite_nxt = 1'b1;
          paddr_nxt  = reg_addr(idx_inc);
          case (idx_inc)
            2'd1:    pwdata_nxt = AMBA_WORD'(width_q);
            2'd2:    pwdata_nxt = noise_q;
            default: pwdata_nxt = AMBA_WORD'(op_q);
          endcase
        end
      end

      // Done takes priority over the timeout on the last allowed cycle
      S_WAIT_DONE: begin
        if (operation_done) begin
          state_nxt       = S_RESP;
          rsp_valid_nxt   = 1'b1;
          rsp_data_nxt    = data_out;
          rsp_num_err_nxt = num_of_errors;
          rsp_status_nxt  = ST_OK;
        end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_nxt       = S_RESP;
          rsp_valid_nxt   = 1'b1;
          rsp_data_nxt    = '0;
          rsp_num_err_nxt = '0;
          rsp_status_nxt  = ST_TIMEOUT;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      S_RESP: begin
        if (rsp_valid && rsp_ready) begin
          state_nxt     = S_IDLE;
          rsp_valid_nxt = 1'b0;
          req_ready_nxt = 1'b1;
        end
      end

      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      idx         <= '0;
      cnt         <= '0;
      op_q        <= '0;
      width_q     <= '0;
      noise_q     <= '0;
      req_ready   <= 1'b1;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      rsp_num_err <= '0;
      rsp_status  <= '0;
    end else begin
      state       <= state_nxt;
      idx         <= idx_nxt;
      cnt         <= cnt_nxt;
      req_ready   <= req_ready_nxt;
      PSEL        <= psel_nxt;
      PENABLE     <= penable_nxt;
      PWRITE      <= pwrite_nxt;
      PADDR       <= paddr_nxt;
      PWDATA      <= pwdata_nxt;
      rsp_valid   <= rsp_valid_nxt;
      rsp_data    <= rsp_data_nxt;
      rsp_num_err <= rsp_num_err_nxt;
      rsp_status  <= rsp_status_nxt;
      if (accept) begin
        op_q    <= req_op;
        width_q <= req_width;
        noise_q <= req_noise;
      end
    end
  end

endmodule

// File: tb/tb_ecc_apb_sequencer.sv
// Bench for ecc_apb_sequencer: directed and random requests, a behavioural ECC
// slave, and scoreboard queues for the expected APB writes and responses.
module tb_ecc_apb_sequencer;

  localparam int unsigned AW    = 20;
  localparam int unsigned DW    = 32;
  localparam int unsigned DATAW = 32;
  localparam int unsigned TMO   = 64;
  localparam logic [AW-1:0] BASE = '0;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [1:0]       req_op = '0;
  logic [DW-1:0]    req_data = '0;
  logic [1:0]       req_width = '0;
  logic [DW-1:0]    req_noise = '0;
  logic [AW-1:0]    PADDR;
  logic [DW-1:0]    PWDATA;
  logic             PSEL, PENABLE, PWRITE;
  logic             operation_done = 1'b0;
  logic [DATAW-1:0] data_out = '0;
  logic [1:0]       num_of_errors = '0;
  logic             rsp_valid;
  logic             rsp_ready = 1'b1;
  logic [DATAW-1:0] rsp_data;
  logic [1:0]       rsp_num_err;
  logic [1:0]       rsp_status;

  ecc_apb_sequencer #(
    .AMBA_ADDR_WIDTH(AW), .AMBA_WORD(DW), .DATA_WIDTH(DATAW),
    .REG_BASE(BASE), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_data(req_data), .req_width(req_width), .req_noise(req_noise),
    .PADDR(PADDR), .PWDATA(PWDATA), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .operation_done(operation_done), .data_out(data_out), .num_of_errors(num_of_errors),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_num_err(rsp_num_err), .rsp_status(rsp_status)
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; } wr_t;
  typedef struct { logic [DATAW-1:0] data; logic [1:0] nerr; logic [1:0] status; int lat; int bp; int acc; } rsp_t;
  typedef struct { int delay; logic [DATAW-1:0] dout; logic [1:0] nerr; } slv_t;

  wr_t  exp_wr[$];
  rsp_t exp_rsp[$];
  slv_t slv_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event missing or unexpected (cycle %0d)", name, cyc);
  endtask

  // Reference model: what one request must produce, from the register map and latencies
  task automatic do_req(input logic [1:0] op, input logic [DW-1:0] data, input logic [1:0] width,
                        input logic [DW-1:0] noise, input int delay, input logic [DATAW-1:0] dout,
                        input logic [1:0] nerr, input int bp, output int acc);
    int   k;
    wr_t  w;
    rsp_t r;
    slv_t s;
    k = 0;
    req_valid = 1'b1; req_op = op; req_data = data; req_width = width; req_noise = noise;
    while (!req_ready && k < 300) begin @(negedge clk); k++; end
    if (!req_ready) begin
      fail("req_accept_timeout");
      req_valid = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc;
    r.bp = bp; r.acc = cyc;
    if (width == 2'd3) begin
      r.data = '0; r.nerr = '0; r.status = 2'b10; r.lat = 1;
    end else begin
      w.addr = BASE + AW'(4);  w.data = data;          exp_wr.push_back(w);
      w.addr = BASE + AW'(8);  w.data = DW'(width);    exp_wr.push_back(w);
      w.addr = BASE + AW'(12); w.data = noise;         exp_wr.push_back(w);
      w.addr = BASE;           w.data = DW'(op);       exp_wr.push_back(w);
      s.delay = delay; s.dout = dout; s.nerr = nerr;   slv_q.push_back(s);
      if (delay >= 0 && delay < int'(TMO)) begin
        r.data = dout; r.nerr = nerr; r.status = 2'b00; r.lat = 10 + delay;
      end else begin
        r.data = '0; r.nerr = '0; r.status = 2'b01; r.lat = 9 + int'(TMO);
      end
    end
    exp_rsp.push_back(r);
    @(negedge clk);
    req_valid = 1'b0;
    req_op = 2'($urandom); req_data = $urandom; req_width = 2'($urandom); req_noise = $urandom;
  endtask

  // Behavioural ECC slave: done after the scheduled WAIT_DONE cycle, stale pulses during writes
  int               done_cd = -1;
  logic [DATAW-1:0] sd;
  logic [1:0]       sn;
  slv_t             slv_cur;
  always @(negedge clk) begin
    operation_done = 1'b0;
    if (rst) begin
      done_cd = -1;
    end else begin
      if (done_cd == 0) begin
        operation_done = 1'b1; data_out = sd; num_of_errors = sn; done_cd = -1;
      end else if (done_cd > 0) begin
        done_cd--;
      end else if (PSEL && $urandom_range(0, 3) == 0) begin
        operation_done = 1'b1; data_out = $urandom; num_of_errors = 2'($urandom);
      end
      if (PSEL && PENABLE && PADDR == BASE && slv_q.size() > 0) begin
        slv_cur = slv_q.pop_front();
        done_cd = slv_cur.delay; sd = slv_cur.dout; sn = slv_cur.nerr;
      end
    end
  end

  // APB monitor: each write is one SETUP then one ACCESS matching the expected queue
  logic prev_setup = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      prev_setup = 1'b0;
    end else if (PSEL) begin
      check("apb_pwrite", 64'(PWRITE), 64'd1);
      if (exp_wr.size() == 0) begin
        fail("apb_unexpected_write");
      end else begin
        check("apb_addr", 64'(PADDR), 64'(exp_wr[0].addr));
        check("apb_data", 64'(PWDATA), 64'(exp_wr[0].data));
        if (PENABLE) begin
          check("apb_access_after_setup", 64'(prev_setup), 64'd1);
          void'(exp_wr.pop_front());
        end else begin
          check("apb_setup_order", 64'(prev_setup), 64'd0);
        end
      end
      prev_setup = !PENABLE;
    end else begin
      check("apb_idle_strobes", 64'({PENABLE, PWRITE}), 64'd0);
      prev_setup = 1'b0;
    end
  end

  // Response monitor and rsp_ready driver with per-response back-pressure
  logic             in_rsp = 1'b0;
  logic             expect_rr = 1'b0;
  int               bp_left = 0;
  logic [DATAW+3:0] snap;
  always @(negedge clk) begin
    if (rst) begin
      in_rsp = 1'b0; expect_rr = 1'b0; rsp_ready = 1'b1;
    end else if (rsp_valid) begin
      check("req_ready_low_in_resp", 64'(req_ready), 64'd0);
      if (!in_rsp) begin
        in_rsp = 1'b1;
        snap = {rsp_data, rsp_num_err, rsp_status};
        if (exp_rsp.size() == 0) begin
          fail("rsp_unexpected");
          bp_left = 0;
        end else begin
          check("rsp_latency", 64'(cyc - exp_rsp[0].acc), 64'(exp_rsp[0].lat));
          bp_left = exp_rsp[0].bp;
        end
      end else begin
        check("rsp_stable", 64'({rsp_data, rsp_num_err, rsp_status}), 64'(snap));
      end
      if (bp_left == 0) begin
        rsp_ready = 1'b1;
        if (exp_rsp.size() > 0) begin
          check("rsp_data", 64'(rsp_data), 64'(exp_rsp[0].data));
          check("rsp_num_err", 64'(rsp_num_err), 64'(exp_rsp[0].nerr));
          check("rsp_status", 64'(rsp_status), 64'(exp_rsp[0].status));
          void'(exp_rsp.pop_front());
        end
        in_rsp = 1'b0;
        expect_rr = 1'b1;
      end else begin
        rsp_ready = 1'b0;
        bp_left--;
      end
    end else begin
      if (expect_rr) begin
        check("req_ready_after_rsp", 64'(req_ready), 64'd1);
        expect_rr = 1'b0;
      end
      rsp_ready = 1'b1;
    end
  end

  task automatic drain();
    int k;
    k = 0;
    while ((exp_rsp.size() > 0 || in_rsp) && k < 500) begin @(negedge clk); k++; end
    if (exp_rsp.size() > 0) fail("drain_timeout");
  endtask

  initial begin
    int acc0, acc1, k, delay, bp;
    logic [1:0] op, width;

    rst = 1'b1;
    @(negedge clk);
    check("rst_psel", 64'(PSEL), 64'd0);
    check("rst_penable", 64'(PENABLE), 64'd0);
    check("rst_pwrite", 64'(PWRITE), 64'd0);
    check("rst_paddr", 64'(PADDR), 64'd0);
    check("rst_pwdata", 64'(PWDATA), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    check("rst_rsp_fields", 64'({rsp_data, rsp_num_err, rsp_status}), 64'd0);
    check("rst_req_ready", 64'(req_ready), 64'd1);
    @(negedge clk);
    rst = 1'b0;

    do_req(2'd0, 32'h0000_00A5, 2'd0, 32'h0, 2, 32'h0000_01A5, 2'd0, 0, acc0);
    do_req(2'd2, 32'hCAFE_0001, 2'd2, 32'h0000_0010, 5, 32'h1234_5678, 2'd1, 0, acc0);
    do_req(2'd1, $urandom, 2'd1, $urandom, -1, 32'h0, 2'd0, 0, acc0);
    do_req(2'd0, $urandom, 2'd3, $urandom, 0, 32'h0, 2'd0, 0, acc0);
    do_req(2'd2, $urandom, 2'd0, $urandom, int'(TMO) - 1, 32'hDEAD_BEEF, 2'd2, 10, acc0);
    do_req(2'd3, $urandom, 2'd3, $urandom, 0, 32'h0, 2'd0, 10, acc0);
    do_req(2'd0, $urandom, 2'd0, $urandom, 0, 32'h0000_0055, 2'd0, 0, acc0);
    do_req(2'd1, $urandom, 2'd1, $urandom, 0, 32'h0000_0077, 2'd3, 0, acc1);
    check("req_spacing", 64'(acc1 - acc0), 64'd11);
    drain();

    // Reset during the NOISE ACCESS cycle aborts without a response
    do_req(2'd2, $urandom, 2'd1, $urandom, 3, 32'h0000_1111, 2'd1, 0, acc0);
    k = 0;
    while (!(PSEL && PENABLE && PADDR == BASE + AW'(12)) && k < 50) begin @(negedge clk); k++; end
    if (k >= 50) fail("noise_access_not_seen");
    rst = 1'b1;
    @(negedge clk);
    check("abort_psel", 64'(PSEL), 64'd0);
    check("abort_penable", 64'(PENABLE), 64'd0);
    check("abort_req_ready", 64'(req_ready), 64'd1);
    check("abort_rsp_valid", 64'(rsp_valid), 64'd0);
    exp_wr.delete(); exp_rsp.delete(); slv_q.delete();
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("abort_no_rsp", 64'(rsp_valid), 64'd0);
    end
    do_req(2'd1, 32'h0F0F_0F0F, 2'd2, 32'h0000_0003, 4, 32'hABCD_0123, 2'd1, 2, acc0);
    drain();

    for (int i = 0; i < 30; i++) begin
      op = 2'($urandom);
      width = ($urandom_range(0, 5) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      case ($urandom_range(0, 5))
        0:       delay = -1;
        1:       delay = int'(TMO) - 1;
        2:       delay = 0;
        default: delay = int'($urandom_range(0, 20));
      endcase
      bp = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 10)) : 0;
      do_req(op, $urandom, width, $urandom, delay, $urandom, 2'($urandom), bp, acc0);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 5)) @(negedge clk);
    end
    drain();
    repeat (5) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
